// File: rtl/and_seq_pkg.sv
// Shared types and helpers for the AND-datapath sequencer.
// Vector count depends only on the pattern mode and the number of AND inputs.
package and_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TAIL = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic {
        MODE_THERM = 1'b0,
        MODE_COUNT = 1'b1
    } mode_e;

    function automatic int unsigned num_vectors(input mode_e mode, input int unsigned n_in);
        return (mode == MODE_COUNT) ? (32'd1 << n_in) : (n_in + 32'd1);
    endfunction

endpackage

// File: rtl/and_seq_pattern.sv
// Combinational vector generator: thermometer fill or binary count of the step index.
module and_seq_pattern
    import and_seq_pkg::*;
#(
    parameter int N_IN = 4
) (
    input  mode_e           mode,
    input  logic [N_IN:0]   step,
    output logic [N_IN-1:0] vec
);

    always_comb begin
        vec = '0;
        if (mode == MODE_COUNT) begin
            vec = step[N_IN-1:0];
        end else begin
            // bit i set once step exceeds i, i.e. (1<<step)-1
            for (int i = 0; i < N_IN; i++) begin
                vec[i] = (int'(step) > i);
            end
        end
    end

endmodule

// File: rtl/and_seq_ctrl.sv
// Sequencer driving the big_and inputs through a vector pattern with per-vector dwell,
// a quiet tail, and a saturating count of cycles where the AND output was high.
module and_seq_ctrl
    import and_seq_pkg::*;
#(
    parameter int N_IN    = 4,
    parameter int DWELL_W = 8,
    parameter int TAIL_W  = 8,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [TAIL_W-1:0]  tail_len,
    input  logic               and_out,
    output logic [N_IN-1:0]    and_in,
    output logic               busy,
    output logic               done,
    output logic [N_IN:0]      step,
    output logic [CNT_W-1:0]   hi_cnt
);

    localparam logic [CNT_W-1:0] HI_MAX = '1;

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [DWELL_W-1:0] dwell_cfg_q, dwell_cfg_d;
    logic [TAIL_W-1:0]  tail_cfg_q, tail_cfg_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [TAIL_W-1:0]  tail_cnt_q, tail_cnt_d;
    logic [N_IN:0]      step_q, step_d;
    logic [CNT_W-1:0]   hi_q, hi_d;
    logic [N_IN:0]      last_step;

    assign last_step = (N_IN+1)'(num_vectors(mode_q, N_IN) - 32'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= MODE_THERM;
            dwell_cfg_q <= '0;
            tail_cfg_q  <= '0;
            dwell_cnt_q <= '0;
            tail_cnt_q  <= '0;
            step_q      <= '0;
            hi_q        <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            dwell_cfg_q <= dwell_cfg_d;
            tail_cfg_q  <= tail_cfg_d;
            dwell_cnt_q <= dwell_cnt_d;
            tail_cnt_q  <= tail_cnt_d;
            step_q      <= step_d;
            hi_q        <= hi_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        dwell_cfg_d = dwell_cfg_q;
        tail_cfg_d  = tail_cfg_q;
        dwell_cnt_d = dwell_cnt_q;
        tail_cnt_d  = tail_cnt_q;
        step_d      = step_q;
        hi_d        = hi_q;

        // the aborting cycle itself still counts; only later cycles are frozen
        if ((state_q == RUN || state_q == TAIL) && and_out && hi_q != HI_MAX) begin
            hi_d = hi_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d     = RUN;
                    mode_d      = mode_e'(mode);
                    dwell_cfg_d = dwell;
                    tail_cfg_d  = tail_len;
                    dwell_cnt_d = dwell;
                    step_d      = '0;
                    hi_d        = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    step_d  = '0;
                end else if (dwell_cnt_q == '0) begin
                    if (step_q != last_step) begin
                        step_d      = step_q + 1'b1;
                        dwell_cnt_d = dwell_cfg_q;
                    end else if (tail_cfg_q != '0) begin
                        state_d    = TAIL;
                        tail_cnt_d = tail_cfg_q - 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q - 1'b1;
                end
            end
            TAIL: begin
                if (abort) begin
                    state_d = IDLE;
                    step_d  = '0;
                end else if (tail_cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    tail_cnt_d = tail_cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // vector(0) is all-zero in both modes, so step=0 after abort/reset yields and_in=0
    and_seq_pattern #(.N_IN(N_IN)) u_pattern (
        .mode (mode_q),
        .step (step_q),
        .vec  (and_in)
    );

    assign busy   = (state_q == RUN) || (state_q == TAIL);
    assign done   = (state_q == DONE);
    assign step   = step_q;
    assign hi_cnt = hi_q;

endmodule

// File: tb/tb_and_seq_ctrl.sv
// Self-checking bench for and_seq_ctrl against a queue-based model of the expected vector stream.
module tb_and_seq_ctrl;

    localparam int N_IN    = 4;
    localparam int DWELL_W = 8;
    localparam int TAIL_W  = 8;
    localparam int CNT_W   = 16;
    localparam int SAT_W   = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               mode = 1'b0;
    logic [DWELL_W-1:0] dwell = '0;
    logic [TAIL_W-1:0]  tail_len = '0;
    logic               and_out;
    logic [N_IN-1:0]    and_in;
    logic               busy, done;
    logic [N_IN:0]      step;
    logic [CNT_W-1:0]   hi_cnt;

    logic               sat_start = 1'b0;
    logic [N_IN-1:0]    sat_and_in;
    logic               sat_busy, sat_done;
    logic [N_IN:0]      sat_step;
    logic [SAT_W-1:0]   sat_hi;

    logic use_rand = 1'b0;
    logic rnd_bit  = 1'b0;
    int   checks = 0;
    int   errors = 0;

    assign and_out = use_rand ? rnd_bit : &and_in;

    always #5 clk = ~clk;

    and_seq_ctrl #(.N_IN(N_IN), .DWELL_W(DWELL_W), .TAIL_W(TAIL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .dwell(dwell), .tail_len(tail_len), .and_out(and_out),
        .and_in(and_in), .busy(busy), .done(done), .step(step), .hi_cnt(hi_cnt)
    );

    and_seq_ctrl #(.N_IN(N_IN), .DWELL_W(DWELL_W), .TAIL_W(TAIL_W), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .rst(rst), .start(sat_start), .abort(abort), .mode(mode),
        .dwell(dwell), .tail_len(tail_len), .and_out(1'b1),
        .and_in(sat_and_in), .busy(sat_busy), .done(sat_done), .step(sat_step), .hi_cnt(sat_hi)
    );

    function automatic int num_vec(input logic m);
        return m ? (1 << N_IN) : (N_IN + 1);
    endfunction

    function automatic logic [N_IN-1:0] vec_of(input logic m, input int k);
        if (m) return N_IN'(k);
        return N_IN'((1 << k) - 1);
    endfunction

    // Runs one sequence; model = flat list of expected (vector, step) per busy cycle.
    task automatic run_seq(input logic m, input int d, input int t,
                           input int abort_at, input int start_pulse_at);
        logic [N_IN-1:0] exp_vec[$];
        logic [N_IN:0]   exp_step[$];
        logic [N_IN-1:0] last_vec;
        int   hi_exp;
        logic ao;
        logic aborted;
        for (int k = 0; k < num_vec(m); k++) begin
            for (int r = 0; r <= d; r++) begin
                exp_vec.push_back(vec_of(m, k));
                exp_step.push_back((N_IN+1)'(k));
            end
        end
        for (int r = 0; r < t; r++) begin
            exp_vec.push_back(vec_of(m, num_vec(m) - 1));
            exp_step.push_back((N_IN+1)'(num_vec(m) - 1));
        end
        last_vec = vec_of(m, num_vec(m) - 1);

        @(negedge clk);
        start = 1'b1; mode = m; dwell = DWELL_W'(d); tail_len = TAIL_W'(t);
        @(negedge clk);
        start = 1'b0;
        mode = 1'($urandom); dwell = DWELL_W'($urandom); tail_len = TAIL_W'($urandom);
        hi_exp  = 0;
        aborted = 1'b0;
        for (int i = 0; i < exp_vec.size(); i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL busy/done cycle %0d: got busy=%b done=%b expected busy=1 done=0", i, busy, done);
            end
            checks++;
            if (and_in !== exp_vec[i] || step !== exp_step[i]) begin
                errors++;
                $display("FAIL and_in/step cycle %0d: got %h/%0d expected %h/%0d", i, and_in, step, exp_vec[i], exp_step[i]);
            end
            if (use_rand) rnd_bit = 1'($urandom);
            ao = use_rand ? rnd_bit : &exp_vec[i];
            if (ao) hi_exp++;
            start = (i == start_pulse_at);
            abort = (i == abort_at);
            @(negedge clk);
            if (i == abort_at) begin
                aborted = 1'b1;
                break;
            end
        end
        start = 1'b0;
        abort = 1'b0;

        if (aborted) begin
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (busy !== 1'b0 || done !== 1'b0 || and_in !== '0 || step !== '0 || hi_cnt !== CNT_W'(hi_exp)) begin
                    errors++;
                    $display("FAIL abort_idle +%0d: got busy=%b done=%b and_in=%h step=%0d hi=%0d expected 0 0 0 0 %0d",
                             c, busy, done, and_in, step, hi_cnt, hi_exp);
                end
                @(negedge clk);
            end
        end else begin
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || hi_cnt !== CNT_W'(hi_exp)) begin
                errors++;
                $display("FAIL done_pulse: got done=%b busy=%b hi=%0d expected done=1 busy=0 hi=%0d", done, busy, hi_cnt, hi_exp);
            end
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int c = 0; c < 2; c++) begin
                checks++;
                if (done !== 1'b0 || busy !== 1'b0 || and_in !== last_vec || hi_cnt !== CNT_W'(hi_exp)) begin
                    errors++;
                    $display("FAIL idle_hold +%0d: got done=%b busy=%b and_in=%h hi=%0d expected 0 0 %h %0d",
                             c, done, busy, and_in, hi_cnt, last_vec, hi_exp);
                end
                @(negedge clk);
            end
        end
        use_rand = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (and_in !== '0 || busy !== 1'b0 || done !== 1'b0 || step !== '0 || hi_cnt !== '0) begin
            errors++;
            $display("FAIL reset: got and_in=%h busy=%b done=%b step=%0d hi=%0d expected all 0", and_in, busy, done, step, hi_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_thermometer();
        run_seq(1'b0, 0, 10, -1, -1);
        checks++;
        if (hi_cnt !== CNT_W'(11)) begin
            errors++;
            $display("FAIL therm_hi: got %0d expected 11", hi_cnt);
        end
    endtask

    task automatic test_binary();
        run_seq(1'b1, 2, 0, -1, -1);
        checks++;
        if (hi_cnt !== CNT_W'(3)) begin
            errors++;
            $display("FAIL binary_hi: got %0d expected 3", hi_cnt);
        end
    endtask

    task automatic test_abort();
        run_seq(1'b0, 0, 10, 8, -1);
        checks++;
        if (hi_cnt !== CNT_W'(5)) begin
            errors++;
            $display("FAIL abort_hi: got %0d expected 5", hi_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [N_IN-1:0] prev_in;
        logic [CNT_W-1:0] prev_hi;
        run_seq(1'b0, 1, 2, -1, 3);
        prev_in = vec_of(1'b0, N_IN);
        prev_hi = CNT_W'(2 + 2);
        @(negedge clk);
        start = 1'b1; abort = 1'b1; mode = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || and_in !== prev_in || hi_cnt !== prev_hi) begin
            errors++;
            $display("FAIL start_abort_idle: got busy=%b done=%b and_in=%h hi=%0d expected 0 0 %h %0d",
                     busy, done, and_in, hi_cnt, prev_in, prev_hi);
        end
        run_seq(1'b1, 0, 1, -1, 10);
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        start = 1'b1; mode = 1'b1; dwell = 8'd1; tail_len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (and_in !== '0 || busy !== 1'b0 || done !== 1'b0 || step !== '0 || hi_cnt !== '0) begin
            errors++;
            $display("FAIL async_reset: got and_in=%h busy=%b done=%b step=%0d hi=%0d expected all 0", and_in, busy, done, step, hi_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: got done=%b busy=%b expected 0 0", done, busy);
        end
        run_seq(1'b1, 0, 3, -1, -1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            int ab;
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 20)) : -1;
            use_rand = 1'b1;
            run_seq(1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 12)), ab,
                    int'($urandom_range(0, 30)));
        end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        sat_start = 1'b1; mode = 1'b0; dwell = 8'd0; tail_len = 8'd30;
        @(negedge clk);
        sat_start = 1'b0;
        for (int i = 0; i < 35; i++) begin
            checks++;
            if (sat_busy !== 1'b1) begin
                errors++;
                $display("FAIL sat_busy cycle %0d: got %b expected 1", i, sat_busy);
            end
            if (i == 10) begin
                checks++;
                if (sat_hi !== SAT_W'(10)) begin
                    errors++;
                    $display("FAIL sat_count: got %0d expected 10", sat_hi);
                end
            end
            if (i == 25) begin
                checks++;
                if (sat_hi !== SAT_W'(15)) begin
                    errors++;
                    $display("FAIL sat_mid: got %0d expected 15", sat_hi);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (sat_done !== 1'b1 || sat_hi !== SAT_W'(15)) begin
            errors++;
            $display("FAIL sat_done: got done=%b hi=%0d expected done=1 hi=15", sat_done, sat_hi);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_thermometer();
        test_binary();
        test_abort();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
